clk_enable_gen: RTL and testbench

CLK_ENABLE_GEN -- requirements
Module: clk_enable_gen

---
 rtl/clk_enable_gen_if.sv | 27 ++
 rtl/clk_enable_gen.sv | 122 ++++++++++++
 tb/tb_clk_enable_gen.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/clk_enable_gen_if.sv
// Configuration bus for the clock-enable generator:
// shadow writes, commit strobe and the bad-channel flag.
interface clk_enable_gen_if #(
   parameter int ACC_W = 16
);
   logic             cfg_wr;
   logic [2:0]       cfg_ch;
   logic [ACC_W-1:0] cfg_inc;
   logic             cfg_commit;
   logic             cfg_err;

   modport master (
      output cfg_wr,
      output cfg_ch,
      output cfg_inc,
      output cfg_commit,
      input  cfg_err
   );

   modport slave (
      input  cfg_wr,
      input  cfg_ch,
      input  cfg_inc,
      input  cfg_commit,
      output cfg_err
   );
endinterface

// File: rtl/clk_enable_gen.sv
// Phase-accumulator clock-enable generator with shadowed increments
// and a settle counter that gates the locked flag.
module clk_enable_gen #(
   parameter int                      NUM_CH      = 4,
   parameter int                      ACC_W       = 16,
   parameter logic [NUM_CH*ACC_W-1:0] DEFAULT_INC =
      {16'd15729, 16'd31457, 16'd32768, 16'd7864},
   parameter int                      LOCK_CYCLES = 16
) (
   input  logic              refclk,
   input  logic              rst_n,
   input  logic              cfg_wr,
   input  logic [2:0]        cfg_ch,
   input  logic [ACC_W-1:0]  cfg_inc,
   input  logic              cfg_commit,
   output logic              cfg_err,
   output logic [NUM_CH-1:0] ce,
   output logic [NUM_CH-1:0] sq,
   output logic              locked
);
   typedef enum logic {
      SETTLE = 1'b0,
      LOCKED = 1'b1
   } lock_e;

   localparam logic [7:0] LOCK_LOAD = 8'(LOCK_CYCLES);

   logic [NUM_CH-1:0][ACC_W-1:0] acc_q, acc_d;
   logic [NUM_CH-1:0][ACC_W-1:0] inc_q, inc_d;
   logic [NUM_CH-1:0][ACC_W-1:0] shd_q, shd_d;
   logic [NUM_CH-1:0][ACC_W-1:0] sum;
   logic [NUM_CH-1:0]            carry;
   logic [NUM_CH-1:0]            hit;
   logic [NUM_CH-1:0]            ce_q, ce_d;
   logic [NUM_CH-1:0]            sq_q, sq_d;
   logic                         err_q, err_d;
   logic                         ch_ok;
   lock_e                        state_q, state_d;
   logic [7:0]                   cnt_q, cnt_d;

   assign ch_ok = ({1'b0, cfg_ch} < 4'(NUM_CH));
   assign err_d = cfg_wr && !ch_ok;

   // A write in the commit cycle lands in the new active set.
   always_comb begin
      acc_d = acc_q;
      inc_d = inc_q;
      shd_d = shd_q;
      sum   = '0;
      carry = '0;
      hit   = '0;
      ce_d  = '0;
      sq_d  = sq_q;
      for (int i = 0; i < NUM_CH; i++) begin
         hit[i] = cfg_wr && (cfg_ch == 3'(i));
         {carry[i], sum[i]} = {1'b0, acc_q[i]} + {1'b0, inc_q[i]};
         if (hit[i]) begin
            shd_d[i] = cfg_inc;
         end
         if (cfg_commit) begin
            inc_d[i] = shd_d[i];
            acc_d[i] = '0;
            sq_d[i]  = 1'b0;
         end else begin
            acc_d[i] = sum[i];
            ce_d[i]  = carry[i];
            sq_d[i]  = sq_q[i] ^ carry[i];
         end
      end
   end

   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
         inc_q <= DEFAULT_INC;
         shd_q <= DEFAULT_INC;
         ce_q  <= '0;
         sq_q  <= '0;
         err_q <= 1'b0;
      end else begin
         acc_q <= acc_d;
         inc_q <= inc_d;
         shd_q <= shd_d;
         ce_q  <= ce_d;
         sq_q  <= sq_d;
         err_q <= err_d;
      end
   end

   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= SETTLE;
         cnt_q   <= LOCK_LOAD;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (cfg_commit) begin
         state_d = SETTLE;
         cnt_d   = LOCK_LOAD;
      end else if (state_q == SETTLE) begin
         if (cnt_q <= 8'd1) begin
            state_d = LOCKED;
         end else begin
            cnt_d = cnt_q - 8'd1;
         end
      end
   end

   always_comb begin
      locked = (state_q == LOCKED);
   end

   assign ce      = ce_q;
   assign sq      = sq_q;
   assign cfg_err = err_q;
endmodule

// File: tb/tb_clk_enable_gen.sv
// Bench for clk_enable_gen: reference model feeding a scoreboard,
// a vector table for config strobes and hand sequences for corners.
module tb_clk_enable_gen;
   typedef logic [9:0] obs_t;

   typedef struct {
      logic        wr;
      logic [2:0]  ch;
      logic [15:0] inc;
      logic        commit;
      logic        exp_err;
      logic        exp_lock;
   } vec_t;

   localparam logic [63:0] DEF =
      {16'd15729, 16'd31457, 16'd32768, 16'd7864};

   logic       refclk;
   logic       rst_n;
   logic [3:0] ce;
   logic [3:0] sq;
   logic       locked;

   clk_enable_gen_if #(.ACC_W(16)) bus ();

   clk_enable_gen dut (
      .refclk     (refclk),
      .rst_n      (rst_n),
      .cfg_wr     (bus.cfg_wr),
      .cfg_ch     (bus.cfg_ch),
      .cfg_inc    (bus.cfg_inc),
      .cfg_commit (bus.cfg_commit),
      .cfg_err    (bus.cfg_err),
      .ce         (ce),
      .sq         (sq),
      .locked     (locked)
   );

   int pass_cnt = 0;
   int chk_cnt  = 0;
   bit sb_on    = 1'b0;

   obs_t        sbq[$];
   obs_t        sb_e;
   int unsigned m_acc[4];
   int unsigned m_inc[4];
   int unsigned m_shd[4];
   int unsigned m_s;
   logic [3:0]  m_ce;
   logic [3:0]  m_sq;
   logic        m_err;
   int          m_since;
   logic [63:0] def_v;

   vec_t tv[4];
   int   cnt0;
   int   cnt1;
   int   cnt2;
   int   cnt3;
   int   z0;

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: got %0h expected %0h t=%0t",
                  name, act, exp, $time);
      end
   endtask

   task automatic idle();
      bus.cfg_wr     = 1'b0;
      bus.cfg_ch     = 3'd0;
      bus.cfg_inc    = 16'd0;
      bus.cfg_commit = 1'b0;
   endtask

   initial begin
      refclk = 1'b0;
      forever #5 refclk = ~refclk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   // Reference model: one step per rising edge, results queued.
   initial begin
      def_v = DEF;
      forever begin
         @(posedge refclk or negedge rst_n);
         if (rst_n !== 1'b1) begin
            for (int i = 0; i < 4; i++) begin
               m_acc[i] = 0;
               m_inc[i] = 32'(def_v[i*16 +: 16]);
               m_shd[i] = m_inc[i];
            end
            m_ce    = '0;
            m_sq    = '0;
            m_err   = 1'b0;
            m_since = 0;
            sbq.delete();
         end else begin
            for (int i = 0; i < 4; i++) begin
               m_s = m_acc[i] + m_inc[i];
               if (bus.cfg_commit) begin
                  if (bus.cfg_wr && bus.cfg_ch == 3'(i))
                     m_inc[i] = 32'(bus.cfg_inc);
                  else
                     m_inc[i] = m_shd[i];
                  m_acc[i] = 0;
                  m_ce[i]  = 1'b0;
                  m_sq[i]  = 1'b0;
               end else begin
                  m_acc[i] = m_s % 65536;
                  m_ce[i]  = (m_s >= 65536);
                  if (m_s >= 65536) m_sq[i] = ~m_sq[i];
               end
            end
            if (bus.cfg_wr && int'(bus.cfg_ch) < 4)
               m_shd[bus.cfg_ch[1:0]] = 32'(bus.cfg_inc);
            m_err   = bus.cfg_wr && int'(bus.cfg_ch) >= 4;
            m_since = bus.cfg_commit ? 0 : m_since + 1;
            if (sb_on)
               sbq.push_back({m_ce, m_sq, (m_since >= 16), m_err});
         end
      end
   end

   initial begin
      forever begin
         @(negedge refclk);
         if (rst_n === 1'b1 && sbq.size() > 0) begin
            sb_e = sbq.pop_front();
            check("scoreboard", 32'({ce, sq, locked, bus.cfg_err}),
                  32'(sb_e));
         end
      end
   end

   initial begin
      tv[0] = '{1'b1, 3'd2, 16'd16384, 1'b0, 1'b0, 1'b1};
      tv[1] = '{1'b1, 3'd5, 16'd1234,  1'b0, 1'b1, 1'b1};
      tv[2] = '{1'b0, 3'd0, 16'd0,     1'b0, 1'b0, 1'b1};
      tv[3] = '{1'b0, 3'd0, 16'd0,     1'b1, 1'b0, 1'b0};

      rst_n = 1'b0;
      idle();
      repeat (3) @(negedge refclk);
      check("rst_ce", 32'(ce), 32'(0));
      check("rst_sq", 32'(sq), 32'(0));
      check("rst_locked", 32'(locked), 32'(0));
      check("rst_err", 32'(bus.cfg_err), 32'(0));

      // Release: defaults, ch1 at half rate.
      sb_on = 1'b1;
      #3 rst_n = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge refclk);
         check($sformatf("rel_lock_k%0d", k), 32'(locked),
               32'(k >= 16));
         check($sformatf("rel_ce1_k%0d", k), 32'(ce[1]),
               32'(k % 2 == 0));
         check($sformatf("rel_sq1_k%0d", k), 32'(sq[1]),
               32'((k / 2) % 2));
      end

      // One full accumulator period: pulse count equals increment.
      sb_on = 1'b0;
      cnt0 = 0; cnt1 = 0; cnt2 = 0; cnt3 = 0;
      for (int n = 0; n < 65536; n++) begin
         @(negedge refclk);
         cnt0 += int'(ce[0]);
         cnt1 += int'(ce[1]);
         cnt2 += int'(ce[2]);
         cnt3 += int'(ce[3]);
      end
      check("count_ch0", 32'(cnt0), 32'(7864));
      check("count_ch1", 32'(cnt1), 32'(32768));
      check("count_ch2", 32'(cnt2), 32'(31457));
      check("count_ch3", 32'(cnt3), 32'(15729));
      sb_on = 1'b1;

      for (int i = 0; i < 4; i++) begin
         bus.cfg_wr     = tv[i].wr;
         bus.cfg_ch     = tv[i].ch;
         bus.cfg_inc    = tv[i].inc;
         bus.cfg_commit = tv[i].commit;
         @(negedge refclk);
         check($sformatf("tv%0d_err", i), 32'(bus.cfg_err),
               32'(tv[i].exp_err));
         check($sformatf("tv%0d_lock", i), 32'(locked),
               32'(tv[i].exp_lock));
      end
      idle();
      for (int k = 1; k <= 20; k++) begin
         @(negedge refclk);
         check($sformatf("cm_ce2_k%0d", k), 32'(ce[2]),
               32'(k % 4 == 0));
         check($sformatf("cm_lock_k%0d", k), 32'(locked),
               32'(k >= 16));
      end

      // Zero increment written with commit; recommit mid-settle.
      z0 = 0;
      bus.cfg_wr     = 1'b1;
      bus.cfg_ch     = 3'd0;
      bus.cfg_inc    = 16'd0;
      bus.cfg_commit = 1'b1;
      @(negedge refclk);
      check("z_lock0", 32'(locked), 32'(0));
      z0 += int'(ce[0]);
      idle();
      repeat (9) begin
         @(negedge refclk);
         z0 += int'(ce[0]);
      end
      bus.cfg_commit = 1'b1;
      @(negedge refclk);
      check("rc_lock0", 32'(locked), 32'(0));
      z0 += int'(ce[0]);
      idle();
      for (int k = 1; k <= 20; k++) begin
         @(negedge refclk);
         check($sformatf("rc_lock_k%0d", k), 32'(locked),
               32'(k >= 16));
         z0 += int'(ce[0]);
      end
      check("zero_inc_ce0", 32'(z0), 32'(0));

      // Reset in the middle of SETTLE with a pending shadow write.
      bus.cfg_commit = 1'b1;
      @(negedge refclk);
      idle();
      bus.cfg_wr  = 1'b1;
      bus.cfg_ch  = 3'd1;
      bus.cfg_inc = 16'd1000;
      @(negedge refclk);
      idle();
      repeat (3) @(negedge refclk);
      @(posedge refclk);
      #2;
      rst_n          = 1'b0;
      bus.cfg_commit = 1'b1;
      bus.cfg_wr     = 1'b1;
      bus.cfg_ch     = 3'd3;
      bus.cfg_inc    = 16'd55;
      #1;
      check("arst_ce", 32'(ce), 32'(0));
      check("arst_sq", 32'(sq), 32'(0));
      check("arst_lock", 32'(locked), 32'(0));
      @(negedge refclk);
      @(negedge refclk);
      idle();
      #3 rst_n = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge refclk);
         check($sformatf("rr_lock_k%0d", k), 32'(locked),
               32'(k >= 16));
         check($sformatf("rr_ce1_k%0d", k), 32'(ce[1]),
               32'(k % 2 == 0));
      end
      bus.cfg_commit = 1'b1;
      @(negedge refclk);
      idle();
      for (int k = 1; k <= 6; k++) begin
         @(negedge refclk);
         check($sformatf("rr_cm_ce1_k%0d", k), 32'(ce[1]),
               32'(k % 2 == 0));
      end
      repeat (2) @(negedge refclk);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule
